// File: rtl/mult_pkg.sv
// Shared encodings for the shift-and-add multiplier: FSM states and operand mode.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/pp_row.sv
// One partial-product row: multiplicand gated by the current multiplier bit,
// zero-extended to 2*WIDTH and shifted to the weight of the current iteration.
module pp_row #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mbit,
  input  logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] row
);

  logic [2*WIDTH-1:0] row_ext;

  always_comb begin
    row_ext = {{WIDTH{1'b0}}, mcand & {WIDTH{mbit}}};
    row     = row_ext << cnt;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one partial-product row per clock, with
// unsigned or signed operands handled as magnitudes plus a final sign fix-up.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               MODE,
  input  logic [WIDTH-1:0]   IA,
  input  logic [WIDTH-1:0]   IB,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] OP
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] op_q, op_d;

  logic [WIDTH-1:0]   ia_mag, ib_mag;
  logic [2*WIDTH-1:0] row, acc_sum;

  pp_row #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_pp_row (
    .mcand (mcand_q),
    .mbit  (mplier_q[0]),
    .cnt   (cnt_q),
    .row   (row)
  );

  // The most-negative value negates to itself, which reads correctly as unsigned 2^(W-1).
  always_comb begin
    ia_mag  = (MODE == MODE_SIGNED && IA[WIDTH-1]) ? (~IA + WIDTH'(1)) : IA;
    ib_mag  = (MODE == MODE_SIGNED && IB[WIDTH-1]) ? (~IB + WIDTH'(1)) : IB;
    acc_sum = acc_q + row;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          state_d  = ST_CALC;
          mcand_d  = ia_mag;
          mplier_d = ib_mag;
          sign_d   = (MODE == MODE_SIGNED) & (IA[WIDTH-1] ^ IB[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIN;
          op_d    = sign_q ? -acc_sum : acc_sum;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  assign BUSY = (state_q == ST_CALC);
  assign DONE = (state_q == ST_FIN);
  assign OP   = op_q;

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Parametrised sequential multiplier that forms a 2*WIDTH-bit product from two WIDTH-bit operands by iterative shift-and-add, one partial-product row per clock.
It replaces the fixed 4-bit per-lane partial-product selection with a complete multiplier. It supports unsigned and signed (two's complement) operation, selected per operation.
Operands are accepted through a START/BUSY/DONE handshake. It sits between operand registers and the result bus of the arithmetic datapath.

Parameters:
WIDTH, 4, operand width in bits (>= 2); product width is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
CLK     input   1         rising-edge clock
RST     input   1         asynchronous, active-high reset
START   input   1         request; sampled only when the block is idle or done
MODE    input   1         0 = unsigned, 1 = signed two's complement; sampled with START
IA      input   WIDTH     multiplicand; sampled with START
IB      input   WIDTH     multiplier; sampled with START
BUSY    output  1         high while an operation is in progress
DONE    output  1         one-cycle pulse; OP is valid from this cycle on
OP      output  2*WIDTH   product; held until the next accepted START

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous and active-high.
- Reset values: state=IDLE, BUSY=0, DONE=0, OP=0, internal accumulator, operand and counter registers all 0.
- States:
  - IDLE: BUSY=0, DONE=0.
  - CALC: BUSY=1, DONE=0.
  - FIN: BUSY=0, DONE=1.
- Acceptance:
  - START=1 at a rising edge in IDLE or FIN -> go to CALC.
  - At that edge the block latches |IA|, |IB| (magnitudes when MODE=1 and the MSB is set, raw values otherwise), sign = MODE & (IA[W-1]^IB[W-1]), and clears the accumulator and counter.
- Ignored requests: START in CALC is ignored with no effect. START=0 in FIN -> IDLE.
- CALC iteration, at each edge:
  - if the multiplier LSB is 1, acc += multiplicand << cnt (2*WIDTH-bit add; the carry out is dropped and provably zero);
  - the multiplier shifts right by 1;
  - cnt increments.
- CALC exit: the edge at which cnt reaches WIDTH-1 performs the last iteration, writes OP = sign ? -(final acc) : final acc, and moves to FIN.
- Latency: START sampled at edge k -> iterations at edges k+1 .. k+WIDTH -> DONE high in the cycle after edge k+WIDTH. This is exactly WIDTH+1 edges, fixed and independent of operand values; there is no early termination.
- Back-to-back: START=1 while in FIN re-enters CALC at that edge. DONE then lasts exactly one cycle, and OP keeps the previous result until the new final write.
- OP is registered and changes only at the final CALC edge or on reset.
- Boundary cases:
  - Most-negative operand (IA or IB = 1<<(W-1) with MODE=1): the magnitude equals 2^(W-1) and is representable unsigned in WIDTH bits.
  - Result range: (-2^(W-1))^2 = 2^(2W-2) fits in 2*WIDTH signed bits; the block needs no overflow flag.
  - Zero operand: runs the full WIDTH iterations; OP=0 and the sign correction yields 0, never -0 artefacts.
- Reset mid-operation: RST asserted in any state immediately returns the block to the reset values. No DONE is produced for the aborted operation.

Decomposition:
- Shared package (mult_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIN=2'd2;
  - MODE constants MODE_UNSIGNED=1'b0, MODE_SIGNED=1'b1.
- One natural sub-module, pp_row:
  - combinational WIDTH-bit partial-product row, multiplicand AND-ed with the current multiplier bit, shifted by cnt and zero-extended to 2*WIDTH;
  - instantiated once by shift_add_multiplier.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
1. WIDTH=4, MODE=0, IA=7, IB=5, pulse START -> BUSY high 4 cycles, DONE at edge 5, OP=8'h23 (35).
2. WIDTH=4, MODE=1, IA=4'hD (-3), IB=4'h5 -> OP=8'hF1 (-15); then IA=4'h8, IB=4'h8 -> OP=8'h40 (64); IA=4'h8, IB=4'h7 -> OP=8'hC8 (-56).
3. WIDTH=4, MODE=0, IA=4'hF, IB=4'hF -> OP=8'hE1 (225). Same operands with MODE=1 -> OP=8'h01.
4. START re-pulsed with IA=2, IB=2 during CALC of 3*3 -> ignored; OP=8'h09, exactly one DONE pulse. START held in the FIN cycle with IA=2, IB=3 -> second DONE WIDTH+1 edges later with OP=8'h06, and OP stays 8'h09 in between.
5. RST asserted asynchronously mid-CALC (between edges) -> BUSY, DONE and OP go to 0 immediately. The next START with IA=6, IB=6 gives OP=8'h24 with normal latency.
6. WIDTH=8, MODE=1, IA=8'h80, IB=8'hFF (-128 * -1) -> OP=16'h0080. IA=0 with any IB -> OP=0 after 9 edges.
